// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types and constants used by the fetch stage.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  localparam lc3b_word RESET_PC   = 16'h0000;
  localparam lc3b_word INSN_BYTES = 16'd2;

  // Sequential successor address; wraps modulo 2^16 with no carry out.
  function automatic lc3b_word next_pc(input lc3b_word addr);
    return addr + INSN_BYTES;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush clears only the valid bit, load captures a new instruction.
module if_id_reg
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     load,
  input  logic     flush,
  input  lc3b_word ir_in,
  input  lc3b_word pc_in,
  output logic     valid,
  output lc3b_word ir,
  output lc3b_word pc
);

  logic     valid_q, valid_d;
  lc3b_word ir_q, ir_d;
  lc3b_word pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      ir_d    = ir_in;
      pc_d    = pc_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ir_q    <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign ir    = ir_q;
  assign pc    = pc_q;

endmodule

// File: rtl/if_stage.sv
// LC-3b instruction fetch: single outstanding imem request, one-word skid buffer
// for decode stalls, and a drain state that discards a response orphaned by a redirect.
module if_stage
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     stall,
  input  logic     redirect,
  input  lc3b_word redirect_pc,
  input  logic     imem_resp,
  input  lc3b_word imem_rdata,
  output logic     imem_read,
  output lc3b_word imem_address,
  output logic     if_id_valid,
  output lc3b_word if_id_ir,
  output lc3b_word if_id_pc
);

  fetch_state_e state_q, state_d;
  lc3b_word     pc_q, pc_d;
  lc3b_word     req_addr_q, req_addr_d;
  lc3b_word     buf_ir_q, buf_ir_d;
  lc3b_word     buf_pc_q, buf_pc_d;

  logic         id_load;
  logic         id_flush;
  lc3b_word     id_ir_in;
  lc3b_word     id_pc_in;
  lc3b_word     seq_pc;

  assign seq_pc = next_pc(req_addr_q);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    buf_ir_d   = buf_ir_q;
    buf_pc_d   = buf_pc_q;
    id_load    = 1'b0;
    id_flush   = 1'b0;
    id_ir_in   = imem_rdata;
    id_pc_in   = seq_pc;

    if (redirect) begin
      // Redirect wins over stall and response; any buffered word is stale.
      id_flush = 1'b1;
      buf_ir_d = '0;
      buf_pc_d = '0;
      case (state_q)
        S_REQ: begin
          pc_d = redirect_pc;
          if (imem_resp) begin
            req_addr_d = redirect_pc;
          end else begin
            state_d = S_DRAIN;
          end
        end
        S_HOLD: begin
          pc_d       = redirect_pc;
          req_addr_d = redirect_pc;
          state_d    = S_REQ;
        end
        S_DRAIN: begin
          pc_d = redirect_pc;
          if (imem_resp) begin
            req_addr_d = redirect_pc;
            state_d    = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_resp) begin
            if (stall) begin
              buf_ir_d = imem_rdata;
              buf_pc_d = seq_pc;
              state_d  = S_HOLD;
            end else begin
              id_load    = 1'b1;
              pc_d       = seq_pc;
              req_addr_d = seq_pc;
            end
          end else if (!stall) begin
            id_flush = 1'b1;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            id_load    = 1'b1;
            id_ir_in   = buf_ir_q;
            id_pc_in   = buf_pc_q;
            pc_d       = buf_pc_q;
            req_addr_d = buf_pc_q;
            state_d    = S_REQ;
          end
        end
        S_DRAIN: begin
          // The orphaned response is discarded; refetch from the redirected pc.
          if (!stall) begin
            id_flush = 1'b1;
          end
          if (imem_resp) begin
            req_addr_d = pc_q;
            state_d    = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      buf_ir_q   <= '0;
      buf_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      buf_ir_q   <= buf_ir_d;
      buf_pc_q   <= buf_pc_d;
    end
  end

  assign imem_read    = (state_q != S_HOLD);
  assign imem_address = req_addr_q;

  if_id_reg u_if_id_reg (
    .clk   (clk),
    .reset (reset),
    .load  (id_load),
    .flush (id_flush),
    .ir_in (id_ir_in),
    .pc_in (id_pc_in),
    .valid (if_id_valid),
    .ir    (if_id_ir),
    .pc    (if_id_pc)
  );

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed scenarios plus randomized fetch traffic
// checked against a program-order model of the instruction stream seen by decode.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset, stall, redirect, imem_resp;
  logic [15:0] redirect_pc, imem_rdata;
  logic        imem_read, if_id_valid;
  logic [15:0] imem_address, if_id_ir, if_id_pc;

  always #5 clk = ~clk;

  if_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_resp    (imem_resp),
    .imem_rdata   (imem_rdata),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .if_id_valid  (if_id_valid),
    .if_id_ir     (if_id_ir),
    .if_id_pc     (if_id_pc)
  );

  typedef struct {
    string       name;
    bit          is_id;
    logic        v;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] redir_q[$];
  bit          model_on  = 1'b0;
  bit          final_chk = 1'b0;
  int          checks    = 0;
  int          errors    = 0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'h9E37) ^ {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  task automatic chk(input string n, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", n, got, want, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit st, input bit rd, input logic [15:0] rpc,
                     input bit rsp, input logic [15:0] dat);
    reset       = r;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_resp   = rsp;
    imem_rdata  = dat;
    @(posedge clk);
    #2;
  endtask

  task automatic exp_all(input string n, input bit v, input logic [15:0] ir,
                         input logic [15:0] pc, input bit rd, input logic [15:0] addr);
    exp_t e;
    e.name = n; e.is_id = 1'b1; e.v = v;  e.a = ir;   e.b = pc;
    exp_q.push_back(e);
    e.name = n; e.is_id = 1'b0; e.v = rd; e.a = addr; e.b = 16'h0;
    exp_q.push_back(e);
  endtask

  // Monitor: samples on the falling edge, after the last rising edge has settled.
  initial begin
    exp_t        e;
    logic [15:0] exp_addr  = 16'h0;
    int          consumed  = 0;
    bit          have_prev = 1'b0;
    bit          done_fin  = 1'b0;
    logic        prev_read, prev_resp, prev_reset;
    logic [15:0] prev_addr;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.is_id) begin
          chk({e.name, "_valid"}, {15'h0, if_id_valid}, {15'h0, e.v});
          chk({e.name, "_ir"}, if_id_ir, e.a);
          chk({e.name, "_pc"}, if_id_pc, e.b);
        end else begin
          chk({e.name, "_read"}, {15'h0, imem_read}, {15'h0, e.v});
          chk({e.name, "_addr"}, imem_address, e.a);
        end
      end
      if (have_prev && prev_read === 1'b1 && prev_resp === 1'b0 && prev_reset === 1'b0)
        chk("addr_stable", imem_address, prev_addr);
      have_prev  = 1'b1;
      prev_read  = imem_read;
      prev_resp  = imem_resp;
      prev_reset = reset;
      prev_addr  = imem_address;
      if (model_on) begin
        // Decode takes IF/ID at the next edge when it holds a real word and is not stalled.
        if (if_id_valid === 1'b1 && stall === 1'b0 && reset === 1'b0) begin
          chk("stream_ir", if_id_ir, mem_word(exp_addr));
          chk("stream_pc", if_id_pc, exp_addr + 16'd2);
          exp_addr = exp_addr + 16'd2;
          consumed++;
        end
        if (redirect === 1'b1) begin
          if (redir_q.size() == 0) chk("redir_queue", 16'h0, 16'h1);
          else exp_addr = redir_q.pop_front();
        end
        if (reset === 1'b1) exp_addr = 16'h0;
      end
      if (final_chk && !done_fin) begin
        done_fin = 1'b1;
        chk("stream_progress", {15'h0, (consumed > 200)}, 16'h1);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, including a response arriving during reset
    cyc(1, 0, 0, 16'h0, 0, 16'h0);          exp_all("rst",      0, 16'h0, 16'h0, 1, 16'h0);
    cyc(1, 0, 0, 16'h0, 1, 16'hBEEF);       exp_all("rst_resp", 0, 16'h0, 16'h0, 1, 16'h0);
    // Back-to-back fetch, then a bubble
    cyc(0, 0, 0, 16'h0, 1, 16'h1021);       exp_all("seq0", 1, 16'h1021, 16'h0002, 1, 16'h0002);
    cyc(0, 0, 0, 16'h0, 1, 16'h5262);       exp_all("seq1", 1, 16'h5262, 16'h0004, 1, 16'h0004);
    cyc(0, 0, 0, 16'h0, 1, 16'h6283);       exp_all("seq2", 1, 16'h6283, 16'h0006, 1, 16'h0006);
    cyc(0, 0, 0, 16'h0, 0, 16'h0);          exp_all("bubble", 0, 16'h6283, 16'h0006, 1, 16'h0006);
    // Stall while the word at 0x0004 returns
    cyc(1, 0, 0, 16'h0, 0, 16'h0);          exp_all("rst2", 0, 16'h0, 16'h0, 1, 16'h0);
    cyc(0, 0, 0, 16'h0, 1, 16'hAAAA);       exp_all("pre0", 1, 16'hAAAA, 16'h0002, 1, 16'h0002);
    cyc(0, 0, 0, 16'h0, 1, 16'hBBBB);       exp_all("pre1", 1, 16'hBBBB, 16'h0004, 1, 16'h0004);
    cyc(0, 1, 0, 16'h0, 1, 16'h1021);       exp_all("stall0", 1, 16'hBBBB, 16'h0004, 0, 16'h0004);
    cyc(0, 1, 0, 16'h0, 0, 16'h0);          exp_all("stall1", 1, 16'hBBBB, 16'h0004, 0, 16'h0004);
    cyc(0, 1, 0, 16'h0, 0, 16'h0);          exp_all("stall2", 1, 16'hBBBB, 16'h0004, 0, 16'h0004);
    cyc(0, 0, 0, 16'h0, 0, 16'h0);          exp_all("unstall", 1, 16'h1021, 16'h0006, 1, 16'h0006);
    // Redirect with the request still outstanding
    cyc(0, 0, 0, 16'h0, 1, 16'h2222);       exp_all("pre2", 1, 16'h2222, 16'h0008, 1, 16'h0008);
    cyc(0, 0, 1, 16'h3000, 0, 16'h0);       exp_all("rd_wait0", 0, 16'h2222, 16'h0008, 1, 16'h0008);
    cyc(0, 0, 0, 16'h0, 0, 16'h0);          exp_all("rd_wait1", 0, 16'h2222, 16'h0008, 1, 16'h0008);
    cyc(0, 0, 0, 16'h0, 1, 16'hDEAD);       exp_all("rd_drop", 0, 16'h2222, 16'h0008, 1, 16'h3000);
    cyc(0, 0, 0, 16'h0, 1, 16'h3333);       exp_all("rd_refetch", 1, 16'h3333, 16'h3002, 1, 16'h3002);
    // Redirect coincident with a response and stall
    cyc(0, 1, 1, 16'h4000, 1, 16'h5555);    exp_all("rd_resp", 0, 16'h3333, 16'h3002, 1, 16'h4000);
    cyc(0, 0, 0, 16'h0, 1, 16'h4444);       exp_all("rd_resp_ok", 1, 16'h4444, 16'h4002, 1, 16'h4002);
    // Address wrap
    cyc(0, 0, 1, 16'hFFFE, 1, 16'h6666);    exp_all("wrap_rd", 0, 16'h4444, 16'h4002, 1, 16'hFFFE);
    cyc(0, 0, 0, 16'h0, 1, 16'h7777);       exp_all("wrap", 1, 16'h7777, 16'h0000, 1, 16'h0000);
    // Reset in S_HOLD
    cyc(0, 1, 0, 16'h0, 1, 16'h8888);       exp_all("hold", 1, 16'h7777, 16'h0000, 0, 16'h0000);
    cyc(1, 1, 0, 16'h0, 0, 16'h0);          exp_all("rst_hold", 0, 16'h0, 16'h0, 1, 16'h0);
    cyc(0, 0, 0, 16'h0, 1, 16'h1111);       exp_all("rst_hold_go", 1, 16'h1111, 16'h0002, 1, 16'h0002);
    // Reset in S_DRAIN, overriding a redirect and a response
    cyc(0, 0, 1, 16'h5000, 0, 16'h0);       exp_all("drain", 0, 16'h1111, 16'h0002, 1, 16'h0002);
    cyc(1, 0, 1, 16'h6000, 1, 16'h9999);    exp_all("rst_drain", 0, 16'h0, 16'h0, 1, 16'h0);
    cyc(0, 0, 0, 16'h0, 1, 16'h2222);       exp_all("rst_drain_go", 1, 16'h2222, 16'h0002, 1, 16'h0002);
    // Redirect in S_HOLD discards the buffered word
    cyc(0, 1, 0, 16'h0, 1, 16'hAAAA);       exp_all("hold2", 1, 16'h2222, 16'h0002, 0, 16'h0002);
    cyc(0, 1, 1, 16'h7000, 0, 16'h0);       exp_all("rd_hold", 0, 16'h2222, 16'h0002, 1, 16'h7000);
    cyc(0, 0, 0, 16'h0, 1, 16'h7777);       exp_all("rd_hold_go", 1, 16'h7777, 16'h7002, 1, 16'h7002);
    // Second redirect during drain retargets only the pending fetch address
    cyc(0, 0, 1, 16'h8000, 0, 16'h0);       exp_all("drain_a", 0, 16'h7777, 16'h7002, 1, 16'h7002);
    cyc(0, 0, 1, 16'h9000, 0, 16'h0);       exp_all("drain_b", 0, 16'h7777, 16'h7002, 1, 16'h7002);
    cyc(0, 0, 0, 16'h0, 1, 16'hCCCC);       exp_all("drain_end", 0, 16'h7777, 16'h7002, 1, 16'h9000);
    cyc(0, 0, 0, 16'h0, 1, 16'h1234);       exp_all("drain_go", 1, 16'h1234, 16'h9002, 1, 16'h9002);

    // Randomized traffic against the program-order stream model
    model_on = 1'b1;
    cyc(1, 0, 0, 16'h0, 0, 16'h0);
    for (int i = 0; i < 3000; i++) begin
      bit          r, st, rd, rsp;
      logic [15:0] tgt;
      r   = ($urandom_range(0, 299) == 0);
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 19) == 0);
      tgt = ($urandom_range(0, 5) == 0) ? 16'hFFFC : (16'($urandom()) & 16'hFFFE);
      rsp = (imem_read === 1'b1) && ($urandom_range(0, 9) < 6);
      if (rd) redir_q.push_back(tgt);
      cyc(r, st, rd, tgt, rsp, mem_word(imem_address));
    end
    cyc(0, 1, 0, 16'h0, 0, 16'h0);
    final_chk = 1'b1;
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
